// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, byte-lane offsets,
// FSM encoding and request legality helpers.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] LANE_0 = 2'd0;
   localparam logic [1:0] LANE_1 = 2'd1;
   localparam logic [1:0] LANE_2 = 2'd2;
   localparam logic [1:0] LANE_3 = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RMW_READ,
      ST_WRITE,
      ST_RESP
   } lsu_state_t;

   // Unsigned variants only exist for loads.
   function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
      logic ok;
      case (f3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         F3_BU, F3_HU:     ok = !is_store;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] offset);
      logic ok;
      case (f3)
         F3_H, F3_HU: ok = (offset[0] == 1'b0);
         F3_W:        ok = (offset == LANE_0);
         default:     ok = 1'b1;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling: load extract/extend and sub-word store merge.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] ld_word,
   input  logic [1:0]       ld_offset,
   input  logic [2:0]       ld_funct3,
   output logic [WIDTH-1:0] ld_data,
   input  logic [WIDTH-1:0] st_old,
   input  logic [WIDTH-1:0] st_new,
   input  logic [1:0]       st_offset,
   input  logic [2:0]       st_funct3,
   output logic [WIDTH-1:0] st_word
);

   logic [15:0]      ld_lane;
   logic [WIDTH-1:0] st_mask;
   logic [WIDTH-1:0] st_ins;

   assign ld_lane = 16'(ld_word >> {ld_offset, 3'b000});

   // Pick the addressed lane and sign- or zero-extend it to the full width.
   always_comb begin
      ld_data = '0;
      case (ld_funct3)
         F3_B:    ld_data = {{(WIDTH-8){ld_lane[7]}}, ld_lane[7:0]};
         F3_BU:   ld_data = {{(WIDTH-8){1'b0}}, ld_lane[7:0]};
         F3_H:    ld_data = {{(WIDTH-16){ld_lane[15]}}, ld_lane};
         F3_HU:   ld_data = {{(WIDTH-16){1'b0}}, ld_lane};
         F3_W:    ld_data = ld_word;
         default: ld_data = '0;
      endcase
   end

   // Replace only the addressed byte/halfword lane; a word store replaces everything.
   always_comb begin
      st_mask = '1;
      st_ins  = st_new;
      case (st_funct3)
         F3_B: begin
            st_mask = WIDTH'(8'hFF) << {st_offset, 3'b000};
            st_ins  = WIDTH'(st_new[7:0]) << {st_offset, 3'b000};
         end
         F3_H: begin
            st_mask = WIDTH'(16'hFFFF) << {st_offset, 3'b000};
            st_ins  = WIDTH'(st_new[15:0]) << {st_offset, 3'b000};
         end
         default: begin
            st_mask = '1;
            st_ins  = st_new;
         end
      endcase
      st_word = (st_old & ~st_mask) | (st_ins & st_mask);
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, sequences the data memory
// strobes and returns the extended load data or an error response.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | ready for a request; illegal requests go straight to RESP
// ST_LOAD     | read strobe for a load, word captured and extended
// ST_RMW_READ | read strobe fetching the old word for a sub-word store
// ST_WRITE    | write strobe with the (merged) store word
// ST_RESP     | response held until resp_ready
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_store,
   input  logic [2:0]       req_funct3,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_rdata,
   output logic             resp_err,
   output logic [WIDTH-1:0] mem_addr,
   output logic             mem_read_en,
   output logic             mem_write_en,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata
);

   lsu_state_t       state_q, state_d;
   logic [WIDTH-1:0] addr_q;
   logic [WIDTH-1:0] wdata_q;
   logic [WIDTH-1:0] old_q;
   logic [2:0]       f3_q;
   logic             store_q;

   logic             req_in_range;
   logic             req_err;
   logic [WIDTH-1:0] word_idx;
   logic [WIDTH-1:0] ld_data;
   logic [WIDTH-1:0] st_word;

   assign req_in_range = ({2'b00, req_addr[WIDTH-1:2]} < WIDTH'(DEPTH));
   assign req_err      = !f3_legal(req_store, req_funct3)
                       || !f3_aligned(req_funct3, req_addr[1:0])
                       || !req_in_range;
   assign word_idx     = {2'b00, addr_q[WIDTH-1:2]};

   lsu_align #(.WIDTH(WIDTH)) u_align (
      .ld_word   (mem_rdata),
      .ld_offset (addr_q[1:0]),
      .ld_funct3 (f3_q),
      .ld_data   (ld_data),
      .st_old    (old_q),
      .st_new    (wdata_q),
      .st_offset (addr_q[1:0]),
      .st_funct3 (f3_q),
      .st_word   (st_word)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state and strobe decode; strobes are gated by rst so a transaction
   // caught by reset never reaches the memory.
   always_comb begin
      state_d      = state_q;
      req_ready    = 1'b0;
      resp_valid   = 1'b0;
      mem_read_en  = 1'b0;
      mem_write_en = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (req_err)              state_d = ST_RESP;
               else if (!req_store)      state_d = ST_LOAD;
               else if (req_funct3 == F3_W) state_d = ST_WRITE;
               else                      state_d = ST_RMW_READ;
            end
         end
         ST_LOAD: begin
            mem_read_en = !rst;
            mem_addr    = word_idx;
            state_d     = ST_RESP;
         end
         ST_RMW_READ: begin
            mem_read_en = !rst;
            mem_addr    = word_idx;
            state_d     = ST_WRITE;
         end
         ST_WRITE: begin
            mem_write_en = !rst;
            mem_addr     = word_idx;
            mem_wdata    = st_word;
            state_d      = ST_RESP;
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Request capture, RMW old-word capture and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q     <= '0;
         wdata_q    <= '0;
         old_q      <= '0;
         f3_q       <= '0;
         store_q    <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  addr_q     <= req_addr;
                  wdata_q    <= req_wdata;
                  f3_q       <= req_funct3;
                  store_q    <= req_store;
                  resp_err   <= req_err;
                  resp_rdata <= '0;
               end
            end
            ST_LOAD:     resp_rdata <= store_q ? '0 : ld_data;
            ST_RMW_READ: old_q      <= mem_rdata;
            ST_WRITE:    resp_rdata <= '0;
            ST_RESP: begin
               if (resp_ready) begin
                  resp_err   <= 1'b0;
                  resp_rdata <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a 32-word behavioural memory.
module tb_load_store_unit;
   import lsu_pkg::*;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic [7:0]  lat;
      logic [3:0]  n_rd;
      logic [3:0]  n_wr;
      logic        both;
      logic [31:0] maddr;
      logic [31:0] mwdata;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_read_en, mem_write_en;

   logic [31:0] mem [32];
   logic        pre_en = 1'b0;
   logic [4:0]  pre_idx = '0;
   logic [31:0] pre_val = '0;

   int   n_checks = 0;
   int   n_fails  = 0;
   int   cyc      = 0;
   int   last_accept;
   obs_t obs;
   obs_t sb[$];

   load_store_unit #(.WIDTH(32), .DEPTH(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: combinational read, write at the clock edge, bench preload port.
   assign mem_rdata = (mem_addr < 32) ? mem[mem_addr[4:0]] : 32'h0;
   always @(posedge clk) begin
      if (pre_en) mem[pre_idx] <= pre_val;
      else if (mem_write_en && mem_addr < 32) mem[mem_addr[4:0]] <= mem_wdata;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic obs_t mk(input logic [31:0] rdata, input logic err, input int lat,
                               input int nrd, input int nwr, input logic [31:0] maddr,
                               input logic [31:0] mwdata);
      obs_t e;
      e.rdata = rdata; e.err = err; e.lat = 8'(lat);
      e.n_rd = 4'(nrd); e.n_wr = 4'(nwr); e.both = 1'b0;
      e.maddr = maddr; e.mwdata = mwdata;
      return e;
   endfunction

   task automatic poke(input int idx, input logic [31:0] val);
      pre_en = 1'b1; pre_idx = 5'(idx); pre_val = val;
      @(posedge clk); #1;
      pre_en = 1'b0;
   endtask

   // Drive one request, push its expectation, observe strobes until the response.
   task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input obs_t e);
      int guard;
      sb.push_back(e);
      obs = '0;
      guard = 0;
      while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
      req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clk); #1;
      last_accept = cyc;
      req_valid = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (mem_read_en) begin obs.n_rd++; obs.maddr = mem_addr; end
         if (mem_write_en) begin obs.n_wr++; obs.maddr = mem_addr; obs.mwdata = mem_wdata; end
         if (mem_read_en && mem_write_en) obs.both = 1'b1;
         if (resp_valid) begin
            obs.lat = 8'(i); obs.rdata = resp_rdata; obs.err = resp_err;
            break;
         end
      end
      if (resp_ready) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      n_checks++;
      if ({req_ready, resp_valid, resp_err, mem_read_en, mem_write_en} !== 5'b10000) begin
         n_fails++;
         $display("FAIL reset_flags: got ready/valid/err/rd/wr=%b want 10000",
                  {req_ready, resp_valid, resp_err, mem_read_en, mem_write_en});
      end
      n_checks++;
      if ({resp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
         n_fails++;
         $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h want all zero",
                  resp_rdata, mem_addr, mem_wdata);
      end
   endtask

   task automatic test_loads();
      logic [2:0]  f3s [8] = '{F3_B, F3_BU, F3_HU, F3_H, F3_W, F3_B, F3_H, F3_B};
      logic [31:0] adr [8] = '{32'h0C, 32'h0D, 32'h0E, 32'h0E, 32'h0C, 32'h0F, 32'h0C, 32'h0E};
      logic [31:0] exp [8] = '{32'hFFFF_FFA5, 32'h0000_00F0, 32'h0000_8070, 32'hFFFF_8070,
                               32'h8070_F0A5, 32'hFFFF_FF80, 32'hFFFF_F0A5, 32'h0000_0070};
      obs_t e;
      poke(3, 32'h8070_F0A5);
      for (int i = 0; i < 8; i++) begin
         do_req(1'b0, f3s[i], adr[i], 32'h0, mk(exp[i], 1'b0, 2, 1, 0, 32'd3, 32'h0));
         e = sb.pop_front();
         n_checks++;
         if (obs !== e) begin
            n_fails++;
            $display("FAIL load[%0d]: got rdata=%h err=%b lat=%0d rd=%0d wr=%0d both=%b addr=%h wd=%h; want rdata=%h err=%b lat=%0d rd=%0d wr=%0d addr=%h wd=%h",
                     i, obs.rdata, obs.err, obs.lat, obs.n_rd, obs.n_wr, obs.both, obs.maddr, obs.mwdata,
                     e.rdata, e.err, e.lat, e.n_rd, e.n_wr, e.maddr, e.mwdata);
         end
      end
   endtask

   task automatic test_store_subword();
      logic        sts [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [2:0]  f3s [6] = '{F3_B, F3_W, F3_H, F3_W, F3_B, F3_BU};
      logic [31:0] adr [6] = '{32'h0D, 32'h0C, 32'h0E, 32'h0C, 32'h0F, 32'h0F};
      logic [31:0] wds [6] = '{32'h1234_5677, 32'h0, 32'h0000_BEEF, 32'h0, 32'h0000_005A, 32'h0};
      obs_t exs [6];
      obs_t e;
      exs[0] = mk(32'h0, 1'b0, 3, 1, 1, 32'd3, 32'hAABB_77DD);
      exs[1] = mk(32'hAABB_77DD, 1'b0, 2, 1, 0, 32'd3, 32'h0);
      exs[2] = mk(32'h0, 1'b0, 3, 1, 1, 32'd3, 32'hBEEF_77DD);
      exs[3] = mk(32'hBEEF_77DD, 1'b0, 2, 1, 0, 32'd3, 32'h0);
      exs[4] = mk(32'h0, 1'b0, 3, 1, 1, 32'd3, 32'h5AEF_77DD);
      exs[5] = mk(32'h0000_005A, 1'b0, 2, 1, 0, 32'd3, 32'h0);
      poke(3, 32'hAABB_CCDD);
      for (int i = 0; i < 6; i++) begin
         do_req(sts[i], f3s[i], adr[i], wds[i], exs[i]);
         e = sb.pop_front();
         n_checks++;
         if (obs !== e) begin
            n_fails++;
            $display("FAIL subword[%0d]: got rdata=%h err=%b lat=%0d rd=%0d wr=%0d both=%b addr=%h wd=%h; want rdata=%h err=%b lat=%0d rd=%0d wr=%0d addr=%h wd=%h",
                     i, obs.rdata, obs.err, obs.lat, obs.n_rd, obs.n_wr, obs.both, obs.maddr, obs.mwdata,
                     e.rdata, e.err, e.lat, e.n_rd, e.n_wr, e.maddr, e.mwdata);
         end
      end
   endtask

   task automatic test_store_word();
      obs_t e;
      do_req(1'b1, F3_W, 32'h7C, 32'hDEAD_BEEF, mk(32'h0, 1'b0, 2, 0, 1, 32'd31, 32'hDEAD_BEEF));
      do_req(1'b0, F3_W, 32'h7C, 32'h0, mk(32'hDEAD_BEEF, 1'b0, 2, 1, 0, 32'd31, 32'h0));
      // Second pop corresponds to the LW; first observation was overwritten, so recheck via memory.
      e = sb.pop_front();
      n_checks++;
      if (mem[31] !== e.mwdata) begin
         n_fails++;
         $display("FAIL sw_mem: got mem[31]=%h want %h", mem[31], e.mwdata);
      end
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin
         n_fails++;
         $display("FAIL sw_lw: got rdata=%h err=%b lat=%0d rd=%0d wr=%0d addr=%h; want rdata=%h lat=%0d rd=%0d addr=%h",
                  obs.rdata, obs.err, obs.lat, obs.n_rd, obs.n_wr, obs.maddr,
                  e.rdata, e.lat, e.n_rd, e.maddr);
      end
   endtask

   task automatic test_errors();
      logic        sts [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [2:0]  f3s [8] = '{F3_H, F3_W, F3_W, 3'b011, F3_HU, F3_W, F3_BU, F3_B};
      logic [31:0] adr [8] = '{32'h01, 32'h06, 32'h80, 32'h00, 32'h03, 32'h02, 32'h00, 32'h80};
      obs_t e;
      for (int i = 0; i < 8; i++) begin
         do_req(sts[i], f3s[i], adr[i], 32'hFFFF_FFFF, mk(32'h0, 1'b1, 1, 0, 0, 32'h0, 32'h0));
         e = sb.pop_front();
         n_checks++;
         if (obs !== e) begin
            n_fails++;
            $display("FAIL err[%0d]: got rdata=%h err=%b lat=%0d rd=%0d wr=%0d; want rdata=%h err=%b lat=%0d rd=0 wr=0",
                     i, obs.rdata, obs.err, obs.lat, obs.n_rd, obs.n_wr, e.rdata, e.err, e.lat);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic        sts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic [2:0]  f3s [4] = '{F3_W, F3_W, F3_B, F3_B};
      logic [31:0] adr [4] = '{32'h0C, 32'h0C, 32'h0C, 32'h0D};
      logic [31:0] wds [4] = '{32'h0, 32'h0, 32'h0000_0011, 32'h0000_0022};
      int          gap [4] = '{0, 3, 0, 4};
      obs_t exs [4];
      obs_t e;
      int   prev;
      exs[0] = mk(32'h0BAD_F00D, 1'b0, 2, 1, 0, 32'd3, 32'h0);
      exs[1] = exs[0];
      exs[2] = mk(32'h0, 1'b0, 3, 1, 1, 32'd3, 32'h0BAD_F011);
      exs[3] = mk(32'h0, 1'b0, 3, 1, 1, 32'd3, 32'h0BAD_2211);
      poke(3, 32'h0BAD_F00D);
      prev = 0;
      for (int i = 0; i < 4; i++) begin
         do_req(sts[i], f3s[i], adr[i], wds[i], exs[i]);
         e = sb.pop_front();
         n_checks++;
         if (obs !== e) begin
            n_fails++;
            $display("FAIL b2b[%0d]: got rdata=%h lat=%0d rd=%0d wr=%0d wd=%h; want rdata=%h lat=%0d rd=%0d wr=%0d wd=%h",
                     i, obs.rdata, obs.lat, obs.n_rd, obs.n_wr, obs.mwdata,
                     e.rdata, e.lat, e.n_rd, e.n_wr, e.mwdata);
         end
         if (gap[i] != 0) begin
            n_checks++;
            if (last_accept - prev !== gap[i]) begin
               n_fails++;
               $display("FAIL b2b_gap[%0d]: got %0d cycles want %0d", i, last_accept - prev, gap[i]);
            end
         end
         prev = last_accept;
      end
   endtask

   task automatic test_hold();
      poke(2, 32'h1122_3344);
      poke(3, 32'h0000_007F);
      resp_ready = 1'b0;
      req_valid = 1'b1; req_store = 1'b0; req_funct3 = F3_W; req_addr = 32'h08; req_wdata = '0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk); @(negedge clk);
      n_checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h1122_3344) begin
         n_fails++;
         $display("FAIL hold_first: got valid=%b rdata=%h want 1 11223344", resp_valid, resp_rdata);
      end
      req_valid = 1'b1; req_funct3 = F3_B; req_addr = 32'h0C;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if ({resp_valid, req_ready, mem_read_en} !== 3'b100 || resp_rdata !== 32'h1122_3344) begin
            n_fails++;
            $display("FAIL hold[%0d]: got valid/ready/rd=%b rdata=%h want 100 11223344",
                     i, {resp_valid, req_ready, mem_read_en}, resp_rdata);
         end
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({resp_valid, req_ready} !== 2'b01) begin
         n_fails++;
         $display("FAIL hold_release: got valid/ready=%b want 01", {resp_valid, req_ready});
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      n_checks++;
      if ({req_ready, mem_read_en} !== 2'b01 || mem_addr !== 32'd3) begin
         n_fails++;
         $display("FAIL hold_accept: got ready/rd=%b addr=%h want 01 3", {req_ready, mem_read_en}, mem_addr);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (resp_valid) break;
      end
      n_checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000_007F) begin
         n_fails++;
         $display("FAIL hold_next: got valid=%b rdata=%h want 1 0000007f", resp_valid, resp_rdata);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      poke(1, 32'h5566_7788);
      req_valid = 1'b1; req_store = 1'b1; req_funct3 = F3_H; req_addr = 32'h06; req_wdata = 32'h0000_AAAA;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (mem_write_en !== 1'b1) begin
         n_fails++;
         $display("FAIL rst_pre_write: got write_en=%b want 1", mem_write_en);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (mem_write_en !== 1'b0) begin
         n_fails++;
         $display("FAIL rst_gate_write: got write_en=%b want 0", mem_write_en);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      n_checks++;
      if ({req_ready, resp_valid, resp_err, mem_read_en, mem_write_en} !== 5'b10000
          || {resp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
         n_fails++;
         $display("FAIL rst_write: got ready/valid/err/rd/wr=%b rdata=%h addr=%h wd=%h want 10000 all zero",
                  {req_ready, resp_valid, resp_err, mem_read_en, mem_write_en}, resp_rdata, mem_addr, mem_wdata);
      end
      @(posedge clk); #1;
      n_checks++;
      if (mem[1] !== 32'h5566_7788) begin
         n_fails++;
         $display("FAIL rst_write_mem: got %h want 55667788", mem[1]);
      end
      req_valid = 1'b1; req_store = 1'b1; req_funct3 = F3_B; req_addr = 32'h05; req_wdata = 32'h99;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n_checks++;
      if (mem_read_en !== 1'b1) begin
         n_fails++;
         $display("FAIL rst_pre_rmw: got read_en=%b want 1", mem_read_en);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (mem[1] !== 32'h5566_7788 || req_ready !== 1'b1 || mem_write_en !== 1'b0) begin
         n_fails++;
         $display("FAIL rst_rmw: got mem=%h ready=%b wr=%b want 55667788 1 0", mem[1], req_ready, mem_write_en);
      end
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
      resp_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_loads();
      test_store_subword();
      test_store_word();
      test_errors();
      test_back_to_back();
      test_hold();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Pipeline-side initiator for the word-wide data memory.
- Accepts RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) over a valid/ready handshake.
- Drives memory read/write strobes, performs sub-word stores as read-modify-write, and returns aligned, sign/zero-extended load data.
- Sits between the execute stage and the data memory.

Parameters:
- WIDTH, 32, data and byte-address width.
- DEPTH, 32, memory depth in words; word indices at or above DEPTH are out of range.

Ports:
- clk  input  1  clock, all state changes on rising edge
- rst  input  1  synchronous active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit idle and can accept
- req_store  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I funct3 size/sign code
- req_addr  input  WIDTH  byte address
- req_wdata  input  WIDTH  store data, right-aligned
- resp_valid  output  1  response available
- resp_ready  input  1  consumer accepts response
- resp_rdata  output  WIDTH  extended load data; 0 for stores and errors
- resp_err  output  1  misaligned, out-of-range or illegal funct3
- mem_addr  output  WIDTH  word index (byte address >> 2)
- mem_read_en  output  1  read strobe
- mem_write_en  output  1  write strobe; memory writes at the clock edge
- mem_wdata  output  WIDTH  word to write
- mem_rdata  input  WIDTH  combinational read data for mem_addr

Behaviour:
- Reset values: FSM to IDLE; resp_valid, resp_err, mem_read_en and mem_write_en 0; resp_rdata, mem_addr and mem_wdata 0. Reset wins over every other event, including mid-transaction; a pending store is abandoned unwritten.
- States: IDLE, LOAD, RMW_READ, WRITE, RESP.
- req_ready = 1 only in IDLE. A request is accepted on a clock edge with req_valid & req_ready; at that edge the address, funct3, store flag and wdata are registered.
- Legal funct3:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Anything else is illegal.
- Alignment:
  - Halfword requires addr[0] = 0.
  - Word requires addr[1:0] = 0.
  - Byte is always aligned.
- Range: addr >> 2 must be < DEPTH.
- Error path: IDLE -> RESP with resp_err = 1, resp_rdata = 0. No memory strobe is ever asserted.
- Load: IDLE -> LOAD -> RESP.
  - LOAD lasts 1 cycle with mem_read_en = 1 and mem_addr = word index.
  - mem_rdata is captured at the end of LOAD, then the lane is selected by addr[1:0] and sign- or zero-extended.
  - resp_valid is asserted 2 cycles after acceptance.
- Word store: IDLE -> WRITE -> RESP. WRITE lasts 1 cycle with mem_write_en = 1 and mem_wdata = req_wdata.
- Sub-word store: IDLE -> RMW_READ -> WRITE -> RESP.
  - RMW_READ lasts 1 cycle with mem_read_en = 1; the old word is captured.
  - In WRITE, the byte/halfword lane selected by addr[1:0] is replaced with the low 8/16 bits of wdata; all other bits are preserved.
- Strobes: mem_read_en and mem_write_en are never both 1. Both are 0 in IDLE and RESP.
- RESP:
  - resp_valid, resp_rdata and resp_err are held stable until resp_ready.
  - The cycle with resp_valid & resp_ready returns the FSM to IDLE, deasserts resp_valid and clears resp_err.
  - No new request is accepted in that same cycle.
  - Back-to-back throughput: load 1 per 3 cycles; sub-word store 1 per 4 cycles.
- req_* inputs are ignored outside IDLE. The registered copies are used throughout the transaction.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants F3_B = 000, F3_H = 001, F3_W = 010, F3_BU = 100, F3_HU = 101.
  - FSM state encoding.
  - Byte-lane offset constants.
- Sub-module lsu_align: purely combinational.
  - Load extract and extend (word, offset, funct3 -> data).
  - Store merge (old word, new data, offset, funct3 -> word).
- The FSM and registers live in load_store_unit.

Test Plan:
- Memory word 3 = 0x8070_F0A5. LB at addr 0x0C -> one LOAD cycle with mem_addr = 3; resp_rdata = 0xFFFF_FFA5, resp_err = 0, resp_valid 2 cycles after acceptance. LBU at 0x0D -> 0x0000_00F0. LHU at 0x0E -> 0x0000_8070.
- SB wdata 0x1234_5677 at addr 0x0D over word 0xAABB_CCDD -> RMW_READ then WRITE with mem_wdata = 0xAABB_77DD. resp_valid 3 cycles after acceptance; a subsequent LW returns 0xAABB_77DD.
- SW 0xDEAD_BEEF at 0x7C -> no read strobe; mem_write_en for 1 cycle with mem_addr = 31. LW at 0x7C -> 0xDEAD_BEEF.
- Error cases, each with resp_err = 1 one cycle after acceptance, resp_rdata = 0, and zero memory strobes:
  - LH at 0x01.
  - LW at 0x06.
  - LW at 0x80 (index 32, DEPTH = 32).
  - Load with funct3 = 011.
- Hold resp_ready = 0 for 5 cycles on an LW response -> resp_valid and resp_rdata stable, req_ready = 0, a new req_valid is ignored. After the handshake: resp_valid = 0, then the new request is accepted.
- Assert rst during the WRITE cycle of an SH -> next cycle in IDLE with all outputs 0 and req_ready = 1. Reset during RMW_READ -> the memory word is unchanged.
